// File: rtl/mult_addsub_pipe.sv
// Purpose : pipelined unsigned RES = C +/- A*B (or RES +/- A*B in accumulate mode), with carry/borrow flag.
// Latency : IN_STAGES + 2 enabled cycles from in_valid to out_valid; one sample per enabled cycle.
// Backpr. : none; CE=0 freezes every register (out_valid included), RST (sync, active-high) beats CE.
//
// Ports:
//   CLK, RST, CE          clock, synchronous active-high reset, clock enable
//   in_valid, A, B, C     operand sample (unsigned, WIDTH bits) and its qualifier
//   add_sub, acc          1 = add / 0 = subtract; 1 = use current RES as base instead of C
//   RES, OVF, out_valid   registered 2*WIDTH result, carry-out/borrow, one-cycle update pulse
// Parameters: WIDTH (operand width), IN_STAGES (input register depth, legal 1..8).
module mult_addsub_pipe #(
    parameter int WIDTH     = 8,
    parameter int IN_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   C,
    input  logic               add_sub,
    input  logic               acc,
    output logic [2*WIDTH-1:0] RES,
    output logic               OVF,
    output logic               out_valid
);
    localparam int RW = 2 * WIDTH;

    typedef struct packed {
        logic             vld;
        logic             add_sub;
        logic             acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } in_t;

    typedef struct packed {
        logic             vld;
        logic             add_sub;
        logic             acc;
        logic [RW-1:0]    p;
        logic [WIDTH-1:0] c;
    } prod_t;

    in_t           in_d [IN_STAGES];
    in_t           in_q [IN_STAGES];
    prod_t         prod_d;
    prod_t         prod_q;
    logic [RW-1:0] res_d;
    logic [RW-1:0] res_q;
    logic          ovf_d;
    logic          ovf_q;
    logic          out_vld_d;
    logic          out_vld_q;

    logic [RW-1:0] base;
    logic [RW:0]   sum;
    logic [RW:0]   diff;

    always_comb begin
        for (int i = 0; i < IN_STAGES; i++) begin
            in_d[i] = in_q[i];
        end
        prod_d    = prod_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        out_vld_d = out_vld_q;

        // Accumulate reads RES as it stands before this edge, so consecutive
        // acc samples chain through the output register without a hazard.
        base = prod_q.acc ? res_q : {{WIDTH{1'b0}}, prod_q.c};
        sum  = {1'b0, base} + {1'b0, prod_q.p};
        // One extra bit on the difference: its MSB is set exactly when P > base.
        diff = {1'b0, base} - {1'b0, prod_q.p};

        if (CE) begin
            in_d[0].vld     = in_valid;
            in_d[0].add_sub = add_sub;
            in_d[0].acc     = acc;
            in_d[0].a       = A;
            in_d[0].b       = B;
            in_d[0].c       = C;
            for (int i = 1; i < IN_STAGES; i++) begin
                in_d[i] = in_q[i-1];
            end

            prod_d.vld     = in_q[IN_STAGES-1].vld;
            prod_d.add_sub = in_q[IN_STAGES-1].add_sub;
            prod_d.acc     = in_q[IN_STAGES-1].acc;
            prod_d.c       = in_q[IN_STAGES-1].c;
            prod_d.p       = {{WIDTH{1'b0}}, in_q[IN_STAGES-1].a}
                           * {{WIDTH{1'b0}}, in_q[IN_STAGES-1].b};

            out_vld_d = prod_q.vld;
            // Bubbles leave RES/OVF untouched so they never disturb the accumulator.
            if (prod_q.vld) begin
                if (prod_q.add_sub) begin
                    {ovf_d, res_d} = sum;
                end else begin
                    {ovf_d, res_d} = diff;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < IN_STAGES; i++) begin
                in_q[i] <= '0;
            end
            prod_q    <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < IN_STAGES; i++) begin
                in_q[i] <= in_d[i];
            end
            prod_q    <= prod_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign RES       = res_q;
    assign OVF       = ovf_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_mult_addsub_pipe.sv
`timescale 1ns/1ps
module tb_mult_addsub_pipe;
    localparam int NCFG = 7;

    function automatic int cfg_w(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 16;
            3: return 4;
            4: return 16;
            5: return 8;
            6: return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 5;
            3: return 5;
            4: return 2;
            5: return 5;
            6: return 1;
            default: return 2;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sweeps_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed instance at default parameters
    // ------------------------------------------------------------------
    logic        rst, ce, iv, as_, ac;
    logic [7:0]  a, b, c;
    logic [15:0] res;
    logic        ovf, ov;

    mult_addsub_pipe #(.WIDTH(8), .IN_STAGES(2)) u_dut (
        .CLK(clk), .RST(rst), .CE(ce), .in_valid(iv),
        .A(a), .B(b), .C(c), .add_sub(as_), .acc(ac),
        .RES(res), .OVF(ovf), .out_valid(ov)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] tc, input logic tas, input logic tac);
        iv = v; a = ta; b = tb_; c = tc; as_ = tas; ac = tac;
    endtask

    // One isolated sample: measure cycles to out_valid and check the result.
    task automatic one_shot(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                            input logic [7:0] tc, input logic tas, input logic tac,
                            input logic [15:0] e_res, input logic e_ovf);
        int lat;
        drive(1'b1, ta, tb_, tc, tas, tac);
        tick();
        iv  = 1'b0;
        lat = 1;
        while (ov !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'd4);
        check_eq({tag, "_res"}, 64'(res), 64'(e_res));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    endtask

    initial begin
        logic [7:0]  ea [4];
        logic [7:0]  eb [4];
        logic [15:0] er [4];
        bit          pat [6];
        int          e, k;
        bit          ce_now, x_ov, x_ovf;
        logic [15:0] x_res;

        ea = '{8'd1, 8'd2, 8'd4, 8'd10};
        eb = '{8'd1, 8'd3, 8'd5, 8'd10};
        er = '{16'd1, 16'd7, 16'd27, 16'd127};
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; ce = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_res", 64'(res), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_vld", 64'(ov), 64'd0);

        one_shot("add_single", 8'd15, 8'd17, 8'd10, 1'b1, 1'b0, 16'd265, 1'b0);
        one_shot("sub_borrow", 8'd3, 8'd4, 8'd5, 1'b0, 1'b0, 16'hFFF9, 1'b1);
        one_shot("sub_ok", 8'd2, 8'd2, 8'd9, 1'b0, 1'b0, 16'd5, 1'b0);
        one_shot("wrap_base", 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 16'd65280, 1'b0);
        one_shot("wrap_acc1", 8'd1, 8'd1, 8'd0, 1'b1, 1'b1, 16'd65281, 1'b0);
        one_shot("wrap_acc2", 8'd255, 8'd1, 8'd0, 1'b1, 1'b1, 16'd0, 1'b1);

        // Back-to-back accumulate from a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ea[i], eb[i], 8'd99, 1'b1, 1'b1);
            tick();
        end
        iv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("b2b_vld%0d", i), 64'(ov), 64'd1);
            check_eq($sformatf("b2b_res%0d", i), 64'(res), 64'(er[i]));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("b2b_hold_vld%0d", i), 64'(ov), 64'd0);
            check_eq($sformatf("b2b_hold_res%0d", i), 64'(res), 64'd127);
            tick();
        end
        one_shot("acc_gap", 8'd3, 8'd4, 8'd0, 1'b1, 1'b1, 16'd139, 1'b0);

        // Gapped stream with CE low for two cycles; garbage offered while CE=0.
        e = 0; k = 0; x_ov = 1'b0; x_res = 16'd139; x_ovf = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            ce_now = !(cyc == 3 || cyc == 4);
            ce = ce_now;
            if (!ce_now) begin
                drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
            end else if (k < 6) begin
                drive(pat[k], 8'(k + 1), 8'd2, 8'(k), 1'b1, 1'b0);
                k++;
            end else begin
                iv = 1'b0;
            end
            tick();
            if (ce_now) begin
                e++;
                if (e >= 4 && e < 10 && pat[e-4]) begin
                    x_ov  = 1'b1;
                    x_res = 16'(2 * (e - 3) + (e - 4));
                    x_ovf = 1'b0;
                end else begin
                    x_ov = 1'b0;
                end
            end
            check_eq($sformatf("ce_vld_c%0d", cyc), 64'(ov), 64'(x_ov));
            check_eq($sformatf("ce_res_c%0d", cyc), 64'(res), 64'(x_res));
            check_eq($sformatf("ce_ovf_c%0d", cyc), 64'(ovf), 64'(x_ovf));
        end
        ce = 1'b1;

        // Three samples in flight, then reset coinciding with CE low.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd7, 8'd9, 8'd5, 1'b1, 1'b0);
            tick();
        end
        iv = 1'b0; rst = 1'b1; ce = 1'b0;
        tick();
        rst = 1'b0; ce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("midrst_vld%0d", i), 64'(ov), 64'd0);
            check_eq($sformatf("midrst_res%0d", i), 64'(res), 64'd0);
            check_eq($sformatf("midrst_ovf%0d", i), 64'(ovf), 64'd0);
            tick();
        end
        one_shot("post_rst_acc", 8'd3, 8'd3, 8'd200, 1'b1, 1'b1, 16'd9, 1'b0);

        for (int i = 0; i < 5000 && sweeps_done < NCFG; i++) begin
            @(posedge clk);
        end
        check_eq("sweeps_done", 64'(sweeps_done), 64'(NCFG));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ------------------------------------------------------------------
    // Random sweep over WIDTH / IN_STAGES against an arithmetic model
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NCFG; g++) begin : g_sweep
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);
        localparam int L = S + 2;

        logic           s_rst, s_ce, s_iv, s_as, s_ac;
        logic [W-1:0]   s_a, s_b, s_c;
        logic [2*W-1:0] s_res;
        logic           s_ovf, s_ov;

        mult_addsub_pipe #(.WIDTH(W), .IN_STAGES(S)) u_dut (
            .CLK(clk), .RST(s_rst), .CE(s_ce), .in_valid(s_iv),
            .A(s_a), .B(s_b), .C(s_c), .add_sub(s_as), .acc(s_ac),
            .RES(s_res), .OVF(s_ovf), .out_valid(s_ov)
        );

        initial begin
            longint unsigned m_mod, m_res, base, prod, t, e_res;
            longint unsigned q_res [$];
            bit              q_ovf [$];
            int              q_cyc [$];
            int              cnt;
            bit              e_ovf, e_ov;

            m_mod = 64'd1 << (2 * W);
            m_res = 0; cnt = 0; e_res = 0; e_ovf = 1'b0; e_ov = 1'b0;
            s_rst = 1'b1; s_ce = 1'b1; s_iv = 1'b0; s_as = 1'b0; s_ac = 1'b0;
            s_a = '0; s_b = '0; s_c = '0;
            @(posedge clk); #1;
            @(posedge clk); #1;

            for (int cyc = 0; cyc < 800; cyc++) begin
                s_rst = ($urandom_range(0, 299) == 0);
                s_ce  = ($urandom_range(0, 7) != 0);
                s_iv  = ($urandom_range(0, 3) != 0);
                s_as  = 1'($urandom_range(0, 1));
                s_ac  = ($urandom_range(0, 2) != 0);
                s_a   = W'($urandom);
                s_b   = W'($urandom);
                s_c   = W'($urandom);
                if (!s_rst && s_ce && s_iv) begin
                    base = s_ac ? m_res : 64'(s_c);
                    prod = 64'(s_a) * 64'(s_b);
                    if (s_as) begin
                        t = base + prod;
                        q_ovf.push_back(t >= m_mod);
                        m_res = t % m_mod;
                    end else begin
                        q_ovf.push_back(prod > base);
                        m_res = (base + m_mod - prod) % m_mod;
                    end
                    q_res.push_back(m_res);
                    q_cyc.push_back(cnt + L);
                end
                @(posedge clk); #1;
                if (s_rst) begin
                    q_res.delete(); q_ovf.delete(); q_cyc.delete();
                    m_res = 0; e_res = 0; e_ovf = 1'b0; e_ov = 1'b0;
                end else if (s_ce) begin
                    cnt++;
                    if (q_cyc.size() > 0 && q_cyc[0] == cnt) begin
                        e_ov  = 1'b1;
                        e_res = q_res.pop_front();
                        e_ovf = q_ovf.pop_front();
                        void'(q_cyc.pop_front());
                    end else begin
                        e_ov = 1'b0;
                    end
                end
                check_eq($sformatf("w%0d_s%0d_vld_c%0d", W, S, cyc), 64'(s_ov), 64'(e_ov));
                check_eq($sformatf("w%0d_s%0d_res_c%0d", W, S, cyc), 64'(s_res), e_res);
                check_eq($sformatf("w%0d_s%0d_ovf_c%0d", W, S, cyc), 64'(s_ovf), 64'(e_ovf));
            end
            sweeps_done++;
        end
    end

endmodule

// File: doc/mult_addsub_pipe.md
# mult_addsub_pipe

Parametrised, pipelined unsigned multiply-add/subtract unit: RES = C ± A·B, with configurable operand width, configurable input register depth, a valid qualifier, a clock enable, an accumulate mode that feeds the previous result back in place of C, and a carry/borrow flag. It is the next generation of the team's fixed 8-bit, two-register-input multiply-add/sub block. It sits in the arithmetic datapath between operand sources and downstream consumers that need a registered, flagged result.

## Interface
- WIDTH, 8: operand width of A, B and C; the result width is 2·WIDTH.
- IN_STAGES, 2: number of input register levels on every operand and control input. Legal range 1–8.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CE  in  1  clock enable. When low, every register holds.
- in_valid  in  1  qualifies A, B, C, add_sub and acc on this cycle.
- A  in  WIDTH  multiplicand, unsigned.
- B  in  WIDTH  multiplier, unsigned.
- C  in  WIDTH  addend/minuend, unsigned, zero-extended to 2·WIDTH.
- add_sub  in  1  1 = add, 0 = subtract (base − A·B).
- acc  in  1  1 = use the current RES register as base instead of C.
- RES  out  2·WIDTH  registered result.
- OVF  out  1  registered carry-out (add) or borrow (subtract) of the final operation.
- out_valid  out  1  RES/OVF were updated on this cycle.

## Operation
- Input chain: IN_STAGES registers deep. A, B, C, add_sub, acc and in_valid advance together, one stage per enabled cycle.
- Product stage: a single register captures P = A·B at full 2·WIDTH width, plus the C, add_sub, acc and valid of that sample.
- Output stage: base = acc ? RES : {WIDTH'b0, C}.
  - add: {OVF, RES} ← base + P, computed in 2·WIDTH+1 bits.
  - sub: RES ← (base − P) mod 2^(2·WIDTH); OVF ← (P > base).
- out_valid ← product-stage valid.
- Result wrap-around: modulo 2^(2·WIDTH); overflow is reported only via OVF, never saturated.
- Bubbles: when the product-stage valid is 0, RES and OVF hold their values and out_valid ← 0. Invalid samples therefore never disturb the accumulator.
- Accumulate feedback: the base reads the RES register as it stands before the edge. Back-to-back acc samples chain correctly with no hazard: each acc sample uses the RES produced by the immediately preceding valid sample.
- CE = 0: all pipeline registers, RES, OVF and out_valid hold. out_valid is not forced low, so a consumer must qualify with CE.
- RST = 1 (takes priority over CE): every pipeline register, every valid bit, RES, OVF and out_valid clear to 0 on the next edge. In-flight samples are discarded. After a reset, an acc sample accumulates onto 0.

## Timing
- Latency: IN_STAGES + 2 enabled cycles from in_valid sampled to out_valid high. The default is 4.
- Throughput: one sample per enabled cycle, with no stalls or backpressure.
- Reset values: RES = 0, OVF = 0, out_valid = 0. Internal valid bits = 0.
- out_valid is a one-cycle pulse per valid input sample, in order, with spacing preserved. Gaps in in_valid appear as identical gaps in out_valid.
- Reset mid-stream: if RST is asserted on edge k, no out_valid occurs from that edge until IN_STAGES + 2 cycles after the first post-reset valid input.
- Simultaneous RST and CE = 0: reset wins.

## Test plan
- Defaults, single add: A = 15, B = 17, C = 10, add_sub = 1, acc = 0. Expect out_valid exactly 4 cycles later with RES = 265, OVF = 0.
- Subtract with borrow: A = 3, B = 4, C = 5, add_sub = 0. Expect RES = 0xFFF9 and OVF = 1. Then A = 2, B = 2, C = 9 gives RES = 5, OVF = 0.
- Add wrap at WIDTH = 8 boundary: acc chain starting from C = 255 + 255·255 = 65280. Then acc add with A = 1, B = 1, then with A = 255, B = 1. Expect RES = 65281, then RES = 0x0000 with OVF = 1.
- Accumulate back-to-back: after reset, 4 consecutive valid samples with acc = 1, add, (A, B) = (1,1), (2,3), (4,5), (10,10). Expect RES = 1, 7, 27, 127 on consecutive out_valid cycles. Interleaved invalid cycles leave RES held.
- CE and bubbles: stream of 6 samples with in_valid = 1,0,1,1,0,1 and CE low for 2 cycles mid-stream. Expect the out_valid pattern to match the input pattern, shifted by 4 enabled cycles, with RES/OVF frozen during CE = 0.
- Reset mid-operation, and parameter sweep: assert RST for 1 cycle with 3 samples in flight. Expect no out_valid for those samples and RES = OVF = 0. Repeat the random-compare checks against a reference model for WIDTH ∈ {4, 8, 16} and IN_STAGES ∈ {1, 2, 5}, checking latency = IN_STAGES + 2.
